// File: rtl/aes_pkg.sv
// Shared AES constants and byte-index helpers for the SubBytes/ShiftRows stage.
// Byte k = 4*col + row; ShiftRows is expressed as a source-index lookup.
package aes_pkg;

  localparam int AES_NB          = 4;
  localparam int AES_STATE_BYTES = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  function automatic logic [1:0] col_of(
    input logic [3:0] k
  );
    return k[3:2];
  endfunction

  function automatic logic [1:0] row_of(
    input logic [3:0] k
  );
    return k[1:0];
  endfunction

  function automatic logic [3:0] shift_src(
    input logic [3:0] k,
    input logic       inv
  );
    logic [1:0] c;
    logic [1:0] r;
    logic [1:0] sc;
    c  = col_of(k);
    r  = row_of(k);
    sc = inv ? (c - r) : (c + r);
    return {sc, r};
  endfunction

endpackage

// File: rtl/aes_subbytes_shiftrows_if.sv
// Request/result bundle between the SubBytes/ShiftRows stage and its driver.
// Word layout matches aes_mixcolumns: byte r of column c at stateC[8r+7:8r].
interface aes_subbytes_shiftrows_if;

  logic        start_in;
  logic        inverse;
  logic [31:0] state0;
  logic [31:0] state1;
  logic [31:0] state2;
  logic [31:0] state3;
  logic [31:0] state_out0;
  logic [31:0] state_out1;
  logic [31:0] state_out2;
  logic [31:0] state_out3;
  logic        busy;
  logic        done;

  modport master (
    output start_in, inverse,
    output state0, state1, state2, state3,
    input  state_out0, state_out1,
    input  state_out2, state_out3,
    input  busy, done
  );

  modport slave (
    input  start_in, inverse,
    input  state0, state1, state2, state3,
    output state_out0, state_out1,
    output state_out2, state_out3,
    output busy, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse plus affine map.
// Inverse direction only exists when AES_SBOX_INV_EN is defined.
module aes_sbox (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(
    input logic [7:0] b
  );
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

`ifdef AES_SBOX_INV_EN
  function automatic logic [7:0] inv_affine(
    input logic [7:0] s
  );
    return {s[6:0], s[7]}
      ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]}
      ^ 8'h05;
  endfunction

  always_comb begin
    if (inv) dout = ginv(inv_affine(din));
    else     dout = affine(ginv(din));
  end
`else
  logic unused_inv;
  assign unused_inv = inv;

  always_comb begin
    dout = affine(ginv(din));
  end
`endif

endmodule

// File: rtl/aes_subbytes_shiftrows.sv
// Iterative SubBytes+ShiftRows, BPC bytes per cycle, sticky done.
// Define AES_SBOX_INV_EN to enable the inverse (InvSubBytes/InvShiftRows) path.
module aes_subbytes_shiftrows
  import aes_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  aes_subbytes_shiftrows_if.slave  bus
);

  fsm_e         fsm_q, fsm_d;
  logic         start_in_q;
  logic         start;
  logic [127:0] in_buf_q, in_buf_d;
  logic [127:0] res_q, res_d;
  logic [127:0] out_q, out_d;
  logic         inv_q, inv_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [7:0]   lane_in  [BPC];
  logic [7:0]   lane_out [BPC];

`ifndef AES_SBOX_INV_EN
  logic unused_inverse;
  assign unused_inverse = bus.inverse;
`endif

  // ShiftRows is folded into the read side: lane j fetches its source byte
  always_comb begin
    for (int j = 0; j < BPC; j++) begin
      lane_in[j] = in_buf_q[
        {shift_src(cnt_q + 4'(j), inv_q), 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < BPC; g++) begin : g_lane
    aes_sbox u_sbox (
      .din  (lane_in[g]),
      .inv  (inv_q),
      .dout (lane_out[g])
    );
  end

  assign start = bus.start_in & ~start_in_q;

  always_comb begin
    fsm_d    = fsm_q;
    in_buf_d = in_buf_q;
    res_d    = res_q;
    out_d    = out_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          in_buf_d = {bus.state3, bus.state2,
                      bus.state1, bus.state0};
`ifdef AES_SBOX_INV_EN
          inv_d    = bus.inverse;
`else
          inv_d    = 1'b0;
`endif
          cnt_d    = 4'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          fsm_d    = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < BPC; j++) begin
          res_d[{cnt_q + 4'(j), 3'b000} +: 8] =
            lane_out[j];
        end
        cnt_d = cnt_q + 4'(BPC);
        if (cnt_q == 4'(AES_STATE_BYTES - BPC)) begin
          out_d  = res_d;
          busy_d = 1'b0;
          done_d = 1'b1;
          fsm_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q      <= IDLE;
      start_in_q <= 1'b0;
      in_buf_q   <= '0;
      res_q      <= '0;
      out_q      <= '0;
      inv_q      <= 1'b0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      start_in_q <= bus.start_in;
      in_buf_q   <= in_buf_d;
      res_q      <= res_d;
      out_q      <= out_d;
      inv_q      <= inv_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.state_out0 = out_q[31:0];
  assign bus.state_out1 = out_q[63:32];
  assign bus.state_out2 = out_q[95:64];
  assign bus.state_out3 = out_q[127:96];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes_subbytes_shiftrows.sv
// Bench for aes_subbytes_shiftrows: BPC=1,2,4 instances side by side.
// Compile with AES_SBOX_INV_EN defined to also cover the inverse path.
module tb_aes_subbytes_shiftrows;

`ifdef AES_SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] FIPS_IN =
    128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] FIPS_OUT =
    128'he598271e_f11141b8_ae52b4e0_305dbfd4;

  typedef struct {
    logic [127:0] din;
    bit           inv;
    logic [127:0] exp;
    string        nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];
  logic [127:0] prev_a;

  aes_subbytes_shiftrows_if ifa ();
  aes_subbytes_shiftrows_if ifb ();
  aes_subbytes_shiftrows_if ifc ();

  assign ifb.start_in = ifa.start_in;
  assign ifb.inverse  = ifa.inverse;
  assign ifb.state0   = ifa.state0;
  assign ifb.state1   = ifa.state1;
  assign ifb.state2   = ifa.state2;
  assign ifb.state3   = ifa.state3;
  assign ifc.start_in = ifa.start_in;
  assign ifc.inverse  = ifa.inverse;
  assign ifc.state0   = ifa.state0;
  assign ifc.state1   = ifa.state1;
  assign ifc.state2   = ifa.state2;
  assign ifc.state3   = ifa.state3;

  aes_subbytes_shiftrows #(.BPC(1)) dut_a (
    .clk(clk), .reset(rst_n), .bus(ifa.slave));
  aes_subbytes_shiftrows #(.BPC(2)) dut_b (
    .clk(clk), .reset(rst_n), .bus(ifb.slave));
  aes_subbytes_shiftrows #(.BPC(4)) dut_c (
    .clk(clk), .reset(rst_n), .bus(ifc.slave));

  logic [127:0] out_a, out_b, out_c;
  assign out_a = {ifa.state_out3, ifa.state_out2,
                  ifa.state_out1, ifa.state_out0};
  assign out_b = {ifb.state_out3, ifb.state_out2,
                  ifb.state_out1, ifb.state_out0};
  assign out_c = {ifc.state_out3, ifc.state_out2,
                  ifc.state_out1, ifc.state_out0};

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Brute-force multiplicative inverse, then the FIPS affine bit formula
  task automatic build_tables();
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8]
             ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_op(
    input logic [127:0] din, input bit inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        int sc = inv ? (c - rw + 4) % 4 : (c + rw) % 4;
        logic [7:0] b = din[8*(4*sc+rw) +: 8];
        r[8*(4*c+rw) +: 8] = inv ? isbox_t[b] : sbox_t[b];
      end
    return r;
  endfunction

  task automatic check(input string nm,
    input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] d, input bit iv);
    ifa.state0  = d[31:0];
    ifa.state1  = d[63:32];
    ifa.state2  = d[95:64];
    ifa.state3  = d[127:96];
    ifa.inverse = iv;
  endtask

  task automatic run_op(input logic [127:0] din,
    input bit iv, input logic [127:0] exp, input string nm);
    int lat [3];
    bit held = 1'b1;
    lat = '{-1, -1, -1};
    @(negedge clk);
    ifa.start_in = 1'b0;
    @(negedge clk);
    drive(din, iv);
    ifa.start_in = 1'b1;
    @(posedge clk); #1;
    check({nm, " accept"},
      {ifc.busy, ifb.busy, ifa.busy, ifc.done, ifb.done, ifa.done},
      6'b111000);
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (ifa.done && lat[0] < 0) lat[0] = i;
      if (ifb.done && lat[1] < 0) lat[1] = i;
      if (ifc.done && lat[2] < 0) lat[2] = i;
      if (lat[0] < 0 && out_a !== prev_a) held = 1'b0;
      if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0) break;
    end
    check({nm, " lat1"}, lat[0], 16);
    check({nm, " lat2"}, lat[1], 8);
    check({nm, " lat4"}, lat[2], 4);
    check({nm, " prev held"}, held, 1);
    check({nm, " out1"}, out_a, exp);
    check({nm, " out2"}, out_b, exp);
    check({nm, " out4"}, out_c, exp);
    prev_a = exp;
  endtask

  initial begin
    vec_t tbl [$];
    logic [127:0] a, b, exp;
    bit done_drop;
    build_tables();
    prev_a = '0;
    ifa.start_in = 1'b0;
    drive('0, 1'b0);

    tbl.push_back('{FIPS_IN, 1'b0, FIPS_OUT, "fips"});
    tbl.push_back('{128'h0, 1'b0, {16{8'h63}}, "zero"});
`ifdef AES_SBOX_INV_EN
    tbl.push_back('{FIPS_OUT, 1'b1, FIPS_IN, "fips_inv"});
`else
    tbl.push_back('{FIPS_IN, 1'b1, FIPS_OUT, "inv_ignored"});
`endif

    #12;
    check("reset outs", {out_a, out_b, out_c}, '0);
    check("reset flags",
      {ifa.busy, ifb.busy, ifc.busy,
       ifa.done, ifb.done, ifc.done}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].din, tbl[i].inv, tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 12; i++) begin
      bit iv = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom, $urandom, $urandom};
      run_op(a, iv, ref_op(a, INV_EN && iv), "rand");
    end

    // start_in held high for 40 cycles, data changed mid-run
    a = {$urandom, $urandom, $urandom, $urandom};
    b = ~a;
    exp = ref_op(a, 1'b0);
    @(negedge clk);
    ifa.start_in = 1'b0;
    @(negedge clk);
    drive(a, 1'b0);
    ifa.start_in = 1'b1;
    done_drop = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) drive(b, 1'b0);
      if (i > 18 && !ifa.done) done_drop = 1'b1;
    end
    check("hold done stays", done_drop, 0);
    check("hold out1", out_a, exp);
    check("hold out4", out_c, exp);
    check("hold flags",
      {ifa.busy, ifb.busy, ifc.busy,
       ifa.done, ifb.done, ifc.done}, 6'b000111);
    prev_a = exp;

    // second start pulse while all instances are still running
    a = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_op(a, 1'b0);
    ifa.start_in = 1'b0;
    @(negedge clk);
    drive(a, 1'b0);
    ifa.start_in = 1'b1;
    @(negedge clk);
    ifa.start_in = 1'b0;
    @(negedge clk);
    drive(~a, 1'b0);
    ifa.start_in = 1'b1;
    @(negedge clk);
    ifa.start_in = 1'b0;
    for (int i = 0; i < 30 && !ifa.done; i++)
      @(negedge clk);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pulse out1", out_a, exp);
    check("pulse out2", out_b, exp);
    check("pulse out4", out_c, exp);
    check("pulse flags",
      {ifa.busy, ifb.busy, ifc.busy,
       ifa.done, ifb.done, ifc.done}, 6'b000111);
    prev_a = exp;

    // reset 5 cycles into RUN
    @(negedge clk);
    drive({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    ifa.start_in = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst outs", {out_a, out_b, out_c}, '0);
    check("midrst flags",
      {ifa.busy, ifb.busy, ifc.busy,
       ifa.done, ifb.done, ifc.done}, '0);
    ifa.start_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_a = '0;
    a = {$urandom, $urandom, $urandom, $urandom};
    run_op(a, 1'b0, ref_op(a, 1'b0), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
